pc_next_unit: RTL and testbench

- Fetch-side next-PC stage that consumes the branch comparator's B_eq/B_neq outputs and the decoded jump opcodes.
- Owns the architectural PC register and resolves branch, JAL and JALR targets.
- Squashes wrong-path instructions with a counted flush window.
- Halts cleanly on a misaligned target.
- Sits between the EX-stage comparator and the instruction-fetch address port.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/pc_next_unit_if.sv | 30 +++
 rtl/pc_next_unit_imm_gen.sv | 20 ++
 rtl/pc_next_unit.sv | 122 ++++++++++++
 tb/tb_pc_next_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V opcode/funct3 constants and next-PC state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_JALR = 3'b000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// EX-stage to fetch bundle: comparator results and jump operands in, fetch PC and squash out.
// Latency: n/a (wires only).
// Backpressure: stall is the fetch-side hold request carried toward the PC owner.
interface pc_next_unit_if #(
    parameter int N = 32
);
    logic         stall;
    logic [N-1:0] inst;
    logic [N-1:0] pc_ex;
    logic [N-1:0] A;
    logic         B_eq;
    logic         B_neq;
    logic [N-1:0] pc;
    logic [N-1:0] link_addr;
    logic         redirect;
    logic         flush;
    logic         misalign;

    // Pipeline side drives the EX operands and consumes the fetch address.
    modport master (
        output stall, inst, pc_ex, A, B_eq, B_neq,
        input  pc, link_addr, redirect, flush, misalign
    );

    // The next-PC unit itself.
    modport slave (
        input  stall, inst, pc_ex, A, B_eq, B_neq,
        output pc, link_addr, redirect, flush, misalign
    );
endinterface

// File: rtl/pc_next_unit_imm_gen.sv
// Decodes B, J and I immediates from an instruction word, sign-extended to N bits.
// Latency: combinational.
// Backpressure: none.
module imm_gen #(
    parameter int N = 32
) (
    input  logic [31:0]  inst,
    output logic [N-1:0] imm_b,
    output logic [N-1:0] imm_j,
    output logic [N-1:0] imm_i
);

    // Bit scatter follows the base ISA encodings; bit 0 of B/J offsets is implicit zero.
    always_comb begin
        imm_b = {{(N-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_j = {{(N-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_i = {{(N-12){inst[31]}}, inst[31:20]};
    end

endmodule

// File: rtl/pc_next_unit.sv
// Owns the fetch PC: sequential advance, branch/JAL/JALR redirect, counted wrong-path flush, halt on misaligned target.
// Latency: redirect target appears on pc one cycle after the request; link_addr/redirect are combinational.
// Backpressure: stall holds pc and the flush counter, except an accepted redirect which always loads pc.
module pc_next_unit
    import rv_pkg::*;
#(
    parameter int          N            = 32,
    parameter logic [N-1:0] RESET_PC    = '0,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pc_next_unit_if.slave bus
);

    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [2:0]   FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [N-1:0] imm_b, imm_j, imm_i;
    logic [N-1:0] target;
    logic         is_jal, is_jalr, take, aligned;

    state_t       state_q, state_nxt;
    logic [N-1:0] pc_q, pc_nxt;
    logic [2:0]   flush_cnt_q, flush_cnt_nxt;
    logic         flush_q, flush_nxt;
    logic         misalign_q, misalign_nxt;
    logic         redirect;

    imm_gen #(.N(N)) u_imm_gen (
        .inst  (bus.inst[31:0]),
        .imm_b (imm_b),
        .imm_j (imm_j),
        .imm_i (imm_i)
    );

    // Decode the jump kind and pick the redirect target; sums wrap silently.
    always_comb begin
        is_jal  = (bus.inst[6:0] == OP_JAL);
        is_jalr = (bus.inst[6:0] == OP_JALR) && (bus.inst[14:12] == FUNCT3_JALR);
        // Both comparator outputs high collapses to a single taken branch.
        take    = bus.B_eq | bus.B_neq | is_jal | is_jalr;
        if (is_jalr)
            target = (bus.A + imm_i) & ~{{(N-1){1'b0}}, 1'b1};
        else if (is_jal)
            target = bus.pc_ex + imm_j;
        else
            target = bus.pc_ex + imm_b;
        aligned = (target[1:0] == 2'b00);
    end

    // Next-state and next-PC selection; redirect is only honoured from RUN.
    always_comb begin
        state_nxt     = state_q;
        pc_nxt        = pc_q;
        flush_cnt_nxt = flush_cnt_q;
        flush_nxt     = flush_q;
        misalign_nxt  = misalign_q;
        redirect      = 1'b0;
        case (state_q)
            RUN: begin
                if (take && aligned) begin
                    redirect      = 1'b1;
                    pc_nxt        = target;
                    flush_cnt_nxt = FLUSH_INIT;
                    flush_nxt     = 1'b1;
                    state_nxt     = FLUSH;
                end else if (take) begin
                    misalign_nxt  = 1'b1;
                    state_nxt     = HALT;
                end else if (!bus.stall) begin
                    pc_nxt        = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                // Younger slots are wrong-path, so comparator/jump requests are ignored here.
                if (!bus.stall) begin
                    pc_nxt = pc_q + PC_STEP;
                    if (flush_cnt_q == 3'd1) begin
                        flush_cnt_nxt = 3'd0;
                        flush_nxt     = 1'b0;
                        state_nxt     = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt_q - 3'd1;
                    end
                end
            end
            HALT: begin
                flush_nxt    = 1'b0;
                misalign_nxt = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                flush_nxt = 1'b0;
            end
        endcase
    end

    // State and PC registers; reset overrides everything, including HALT and FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 3'd0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            pc_q        <= pc_nxt;
            flush_cnt_q <= flush_cnt_nxt;
            flush_q     <= flush_nxt;
            misalign_q  <= misalign_nxt;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = bus.pc_ex + PC_STEP;
    assign bus.redirect  = redirect;
    assign bus.flush     = flush_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: fetch sequence, redirects, flush window, misalign halt, wrap, reset.
// Latency: registered outputs sampled 1 ns after posedge; combinational outputs 1 ns after drive.
// Backpressure: stall driven directly from the scenarios.
module tb_pc_next_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_next_unit_if #(.N(32)) bus ();

    pc_next_unit #(
        .N            (32),
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Comparator must never claim both BEQ and BNE taken.
    always @(negedge clk) begin
        if (!rst) assert (!(bus.B_eq && bus.B_neq)) else $error("illegal B_eq and B_neq both high");
    end

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall = 1'b0;
        bus.inst  = NOP;
        bus.pc_ex = 32'h0;
        bus.A     = 32'h0;
        bus.B_eq  = 1'b0;
        bus.B_neq = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", bus.redirect); end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (bus.pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, 32'(i * 4)); end
            checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d] got=%b exp=0", i, bus.flush); end
        end
    endtask

    task automatic test_beq_stall;
        bus.pc_ex = 32'h100;
        bus.inst  = enc_b(13'h020, 3'b000);
        bus.B_eq  = 1'b1;
        bus.stall = 1'b1;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got=%b exp=1", bus.redirect); end
        tick();
        checks++; if (bus.pc !== 32'h120) begin errors++; $display("FAIL beq_target got=%h exp=%h", bus.pc, 32'h120); end
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush0 got=%b exp=1", bus.flush); end
        // Wrong-path BNE pulse inside the flush window.
        bus.B_eq  = 1'b0;
        bus.B_neq = 1'b1;
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL flush_bne_redirect got=%b exp=0", bus.redirect); end
        tick();
        bus.B_neq = 1'b0;
        checks++; if (bus.pc !== 32'h124) begin errors++; $display("FAIL beq_flush_pc1 got=%h exp=%h", bus.pc, 32'h124); end
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush1 got=%b exp=1", bus.flush); end
        tick();
        checks++; if (bus.pc !== 32'h128) begin errors++; $display("FAIL beq_flush_pc2 got=%h exp=%h", bus.pc, 32'h128); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_flush_end got=%b exp=0", bus.flush); end
        idle();
    endtask

    task automatic test_jalr;
        // 0x2001 + 4 = 0x2005; clearing bit 0 leaves an aligned 0x2004.
        bus.pc_ex = 32'h40;
        bus.A     = 32'h2001;
        bus.inst  = enc_jalr(12'h004);
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect got=%b exp=1", bus.redirect); end
        checks++; if (bus.link_addr !== 32'h44) begin errors++; $display("FAIL jalr_link got=%h exp=%h", bus.link_addr, 32'h44); end
        tick();
        idle();
        checks++; if (bus.pc !== 32'h2004) begin errors++; $display("FAIL jalr_target got=%h exp=%h", bus.pc, 32'h2004); end
        tick();
        tick();
        checks++; if (bus.pc !== 32'h200C) begin errors++; $display("FAIL jalr_after_flush got=%h exp=%h", bus.pc, 32'h200C); end
        // 0x2001 + 2 = 0x2003 -> 0x2002: bit 1 set, so this target is misaligned.
        bus.pc_ex = 32'h40;
        bus.A     = 32'h2001;
        bus.inst  = enc_jalr(12'h002);
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL jalr_mis_redirect got=%b exp=0", bus.redirect); end
        checks++; if (bus.link_addr !== 32'h44) begin errors++; $display("FAIL jalr_mis_link got=%h exp=%h", bus.link_addr, 32'h44); end
        tick();
        idle();
        checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL jalr_mis_flag got=%b exp=1", bus.misalign); end
        checks++; if (bus.pc !== 32'h200C) begin errors++; $display("FAIL jalr_mis_pc got=%h exp=%h", bus.pc, 32'h200C); end
        do_reset();
    endtask

    task automatic test_misalign_jal;
        bus.pc_ex = 32'h10;
        bus.inst  = enc_j(21'h000006);
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL jal_mis_redirect got=%b exp=0", bus.redirect); end
        tick();
        checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL jal_mis_flag got=%b exp=1", bus.misalign); end
        // An aligned JAL offered during HALT must still be refused.
        bus.inst = enc_j(21'h000008);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL halt_pc[%0d] got=%h exp=%h", i, bus.pc, 32'h0); end
            checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL halt_redirect[%0d] got=%b exp=0", i, bus.redirect); end
            checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL halt_misalign[%0d] got=%b exp=1", i, bus.misalign); end
            checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL halt_flush[%0d] got=%b exp=0", i, bus.flush); end
        end
        idle();
        rst = 1'b1;
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL halt_reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL halt_reset_misalign got=%b exp=0", bus.misalign); end
        rst = 1'b0;
    endtask

    task automatic test_stall_mid_flush;
        int flush_hi;
        bus.pc_ex = 32'h200;
        bus.inst  = enc_b(13'h040, 3'b001);
        bus.B_neq = 1'b1;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL bne_redirect got=%b exp=1", bus.redirect); end
        tick();
        idle();
        checks++; if (bus.pc !== 32'h240) begin errors++; $display("FAIL bne_target got=%h exp=%h", bus.pc, 32'h240); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h240) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.pc, 32'h240); end
            checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL stall_flush[%0d] got=%b exp=1", i, bus.flush); end
        end
        bus.stall = 1'b0;
        flush_hi  = 0;
        for (int i = 0; i < 6 && bus.flush === 1'b1; i++) begin
            flush_hi++;
            tick();
        end
        checks++; if (flush_hi !== 2) begin errors++; $display("FAIL stall_flush_len got=%0d exp=2", flush_hi); end
        checks++; if (bus.pc !== 32'h248) begin errors++; $display("FAIL stall_flush_pc got=%h exp=%h", bus.pc, 32'h248); end
    endtask

    task automatic test_wrap_reset;
        bus.pc_ex = 32'hFFFF_FFF0;
        bus.inst  = enc_b(13'h020, 3'b000);
        bus.B_eq  = 1'b1;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL wrap_redirect got=%b exp=1", bus.redirect); end
        tick();
        idle();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL wrap_target got=%h exp=%h", bus.pc, 32'h10); end
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL wrap_flush got=%b exp=1", bus.flush); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL midflush_reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL midflush_reset_flush got=%b exp=0", bus.flush); end
        tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc got=%h exp=%h", bus.pc, 32'h4); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL post_reset_flush got=%b exp=0", bus.flush); end
    endtask

    initial begin
        idle();
        test_reset();
        test_sequential();
        test_beq_stall();
        test_jalr();
        test_misalign_jal();
        test_stall_mid_flush();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
